// File: rtl/psum_pkg.sv
// Shared types and constants for the partial-sum sequencing controller.
package psum_pkg;

  // Width of the latched configuration fields; the top-level CW parameter
  // defaults to this and must match it.
  localparam int CFG_W = 8;

  // Minimum idle cycles between an ic_done beat and the next pass's first
  // data_valid: five cycles of done pipeline in the psum file plus one cycle
  // for it to update its bank state.
  localparam int GAP_MIN = 6;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GAP,
    CHECK,
    WAIT_DRAIN,
    FLUSH
  } sched_state_e;

  typedef struct packed {
    logic [CFG_W-1:0] num_ic;
    logic [CFG_W-1:0] num_oc;
    logic [CFG_W-1:0] num_pix;
  } cfg_t;

endpackage

// File: rtl/loop_cnt3.sv
// Nested pixel / input-channel / output-channel loop counter.
// inc_pix steps the innermost pixel loop (wrapping to 0 after the last pixel);
// inc_pass steps the ic loop and carries into the oc loop. The two steps are
// kept separate so the scheduler can hold ic/oc constant through the gap
// between passes while the pixel index has already returned to 0.
module loop_cnt3 #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc_pix,
  input  logic          inc_pass,
  input  logic [CW-1:0] num_pix,
  input  logic [CW-1:0] num_ic,
  input  logic [CW-1:0] num_oc,
  output logic [CW-1:0] pix,
  output logic [CW-1:0] ic,
  output logic [CW-1:0] oc,
  output logic          last_pix,
  output logic          last_ic,
  output logic          last_oc
);

  localparam logic [CW-1:0] ONE = CW'(1);

  // Terminal-count flags for each loop level.
  always_comb begin
    last_pix = (pix == num_pix - ONE);
    last_ic  = (ic  == num_ic  - ONE);
    last_oc  = (oc  == num_oc  - ONE);
  end

  // Index registers; clr restarts the whole nest at a new tile.
  // NOTE: clocked state is written with <= so every register in this block
  // samples the pre-edge values; '=' here would let later statements see
  // already-updated indices and break the nesting.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pix <= '0;
      ic  <= '0;
      oc  <= '0;
    end else begin
      if (inc_pix) begin
        pix <= last_pix ? '0 : pix + ONE;
      end
      if (inc_pass) begin
        if (last_ic) begin
          ic <= '0;
          oc <= last_oc ? '0 : oc + ONE;
        end else begin
          ic <= ic + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/psum_sched.sv
// Sequencing controller for the ping-pong partial-sum register file.
// Walks the oc / ic / pixel loop nest of one tile, issues data_valid,
// ic_done and oc_done beats, inserts the inter-pass gap the psum file's done
// pipeline needs, and stops a bank from refilling before it has drained.
module psum_sched
  import psum_pkg::*;
#(
  parameter int CW     = CFG_W,
  parameter int AWIDTH = 4,
  parameter int IC_GAP = GAP_MIN,
  parameter int RW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cfg_num_ic,
  input  logic [CW-1:0] cfg_num_oc,
  input  logic [CW-1:0] cfg_num_pix,
  input  logic          pe_ready,
  input  logic          result_valid,
  output logic          data_valid,
  output logic          ic_done,
  output logic          oc_done,
  output logic [CW-1:0] pix_idx,
  output logic [CW-1:0] ic_idx,
  output logic [CW-1:0] oc_idx,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  // The gap state lasts IC_GAP-1 cycles; the single CHECK cycle that always
  // follows it supplies the last idle cycle before the next pass.
  localparam int            GW       = $clog2(IC_GAP) + 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(IC_GAP - 2);
  localparam logic [CW:0]   PIX_MAX  = (CW+1)'(2 ** AWIDTH);

  sched_state_e state, state_nxt;
  cfg_t         cfg_q;

  logic [GW-1:0]   gap_cnt;
  logic [RW-1:0]   res_cnt;
  logic [RW-1:0]   thr;
  logic [RW-1:0]   npix_rw;
  logic [RW:0]     drained_plus;
  logic [2*CW-1:0] prod;

  logic cfg_ok;
  logic accept;
  logic reject;
  logic inc_pix;
  logic inc_pass;
  logic gap_end;
  logic drain_ok;
  logic last_pix;
  logic last_ic;
  logic last_oc;

  loop_cnt3 #(
    .CW (CW)
  ) u_loop (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .inc_pix  (inc_pix),
    .inc_pass (inc_pass),
    .num_pix  (cfg_q.num_pix),
    .num_ic   (cfg_q.num_ic),
    .num_oc   (cfg_q.num_oc),
    .pix      (pix_idx),
    .ic       (ic_idx),
    .oc       (oc_idx),
    .last_pix (last_pix),
    .last_ic  (last_ic),
    .last_oc  (last_oc)
  );

  // Configuration screening for a start request. The oc*pix product is only
  // needed here, once per tile; drain tracking uses a running threshold.
  always_comb begin
    prod   = cfg_num_oc * cfg_num_pix;
    cfg_ok = (cfg_num_ic  != '0) &&
             (cfg_num_oc  != '0) &&
             (cfg_num_pix != '0) &&
             ({1'b0, cfg_num_pix} <= PIX_MAX);
    if (RW < 2 * CW) begin
      cfg_ok = cfg_ok && ((prod >> RW) == '0);
    end
  end

  // Drain gate: entering oc k >= 2 at ic 0 needs res_cnt >= (k-1)*npix.
  // thr holds k*npix, so the test is res_cnt + npix >= thr.
  always_comb begin
    npix_rw      = RW'(cfg_q.num_pix);
    drained_plus = {1'b0, res_cnt} + {1'b0, npix_rw};
    drain_ok     = (ic_idx != '0) || (oc_idx < CW'(2)) ||
                   (drained_plus >= {1'b0, thr});
    gap_end      = (gap_cnt == GAP_LAST);
    busy         = (state != IDLE);
  end

  // Next-state and beat outputs.
  // NOTE: every signal driven here gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    reject     = 1'b0;
    inc_pix    = 1'b0;
    inc_pass   = 1'b0;
    data_valid = 1'b0;
    ic_done    = 1'b0;
    oc_done    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            accept    = 1'b1;
            state_nxt = ISSUE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (pe_ready) begin
          data_valid = 1'b1;
          inc_pix    = 1'b1;
          if (last_pix) begin
            ic_done   = 1'b1;
            oc_done   = last_ic;
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (gap_end) begin
          inc_pass  = 1'b1;
          state_nxt = (last_ic && last_oc) ? FLUSH : CHECK;
        end
      end
      CHECK: begin
        state_nxt = drain_ok ? ISSUE : WAIT_DRAIN;
      end
      WAIT_DRAIN: begin
        if (drain_ok) begin
          state_nxt = ISSUE;
        end
      end
      FLUSH: begin
        // The final oc_done also kicks off the last bank's drain, so every
        // result of the tile eventually arrives here.
        if (res_cnt >= thr) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Configuration latch, captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
    end else if (accept) begin
      cfg_q.num_ic  <= cfg_num_ic;
      cfg_q.num_oc  <= cfg_num_oc;
      cfg_q.num_pix <= cfg_num_pix;
    end
  end

  // Gap counter: runs only while in GAP, restarts on every entry.
  always_ff @(posedge clk) begin
    if (rst || state != GAP) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

  // Result counter: counts drain beats of the current tile.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      res_cnt <= '0;
    end else if (busy && result_valid) begin
      res_cnt <= res_cnt + RW'(1);
    end
  end

  // Running drain threshold: npix times the number of oc groups started so
  // far, advanced at every oc carry; ends at noc*npix for the flush.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      thr <= '0;
    end else if (inc_pass && last_ic) begin
      thr <= thr + npix_rw;
    end
  end

  // Rejected-start flag, one cycle after the offending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= reject;
    end
  end

endmodule

// File: tb/tb_psum_sched.sv
// Directed bench for psum_sched: full tiles, config rejection, drain stall,
// operand throttling, mid-tile reset and the degenerate 1x1x1 tile.
module tb_psum_sched;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_num_ic;
  logic [CW-1:0] cfg_num_oc;
  logic [CW-1:0] cfg_num_pix;
  logic          pe_ready;
  logic          result_valid;
  logic          data_valid;
  logic          ic_done;
  logic          oc_done;
  logic [CW-1:0] pix_idx;
  logic [CW-1:0] ic_idx;
  logic [CW-1:0] oc_idx;
  logic          busy;
  logic          done;
  logic          cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  // Per-tile observations gathered by run_tile.
  int r_beats, r_ic_mask, r_oc_mask, r_gap_min, r_gap_max, r_ngaps;
  int r_done_cyc, r_last_res, r_res_sent, r_busy0, r_spurious;
  int ic_at[64];
  int oc_at[64];

  psum_sched #(
    .CW     (CW),
    .AWIDTH (4),
    .IC_GAP (6),
    .RW     (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_num_ic   (cfg_num_ic),
    .cfg_num_oc   (cfg_num_oc),
    .cfg_num_pix  (cfg_num_pix),
    .pe_ready     (pe_ready),
    .result_valid (result_valid),
    .data_valid   (data_valid),
    .ic_done      (ic_done),
    .oc_done      (oc_done),
    .pix_idx      (pix_idx),
    .ic_idx       (ic_idx),
    .oc_idx       (oc_idx),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Present a start with the given config during the next cycle.
  task automatic start_tile(input int nic, input int noc, input int npix);
    @(negedge clk);
    cfg_num_ic   = CW'(nic);
    cfg_num_oc   = CW'(noc);
    cfg_num_pix  = CW'(npix);
    start        = 1'b1;
    pe_ready     = 1'b1;
    result_valid = 1'b0;
  endtask

  // Run a tile with pe_ready=1; each oc_done schedules a burst of results
  // starting 6 cycles later. Stops at done or after budget cycles.
  task automatic run_tile(input int burst, input int budget);
    int sched[$];
    int prev_ic;
    int gap;
    r_beats = 0; r_ic_mask = 0; r_oc_mask = 0; r_gap_min = 999; r_gap_max = -1;
    r_ngaps = 0; r_done_cyc = -1; r_last_res = -100; r_res_sent = 0;
    r_busy0 = 0; r_spurious = 0;
    prev_ic = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start        = 1'b0;
      pe_ready     = 1'b1;
      result_valid = 1'b0;
      if (sched.size() > 0 && sched[0] == c) begin
        void'(sched.pop_front());
        result_valid = 1'b1;
        r_res_sent++;
        r_last_res = c;
      end
      #1;
      if (c == 0) r_busy0 = int'(busy);
      if ((ic_done || oc_done) && !data_valid) r_spurious++;
      if (data_valid) begin
        r_beats++;
        if (prev_ic >= 0) begin
          gap = c - prev_ic - 1;
          if (gap < r_gap_min) r_gap_min = gap;
          if (gap > r_gap_max) r_gap_max = gap;
          r_ngaps++;
          prev_ic = -1;
        end
        if (r_beats < 64) begin
          ic_at[r_beats] = int'(ic_idx);
          oc_at[r_beats] = int'(oc_idx);
        end
        if (ic_done) begin
          r_ic_mask |= (1 << r_beats);
          prev_ic = c;
        end
        if (oc_done) begin
          r_oc_mask |= (1 << r_beats);
          for (int k = 0; k < burst; k++) sched.push_back(c + 6 + k);
        end
      end
      if (done) begin
        r_done_cyc = c;
        break;
      end
    end
    result_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at;
    logic [2:0] exp_pix [5];
    logic       exp_pe  [5];
    exp_pix = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2};
    exp_pe  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; pe_ready = 1'b0; result_valid = 1'b0;
    cfg_num_ic = '0; cfg_num_oc = '0; cfg_num_pix = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_outputs",
          {data_valid, ic_done, oc_done, busy, done, cfg_err, pix_idx, ic_idx, oc_idx}, 0);

    // ---- Tile nic=2 noc=2 npix=4 ----
    start_tile(2, 2, 4);
    run_tile(4, 200);
    check("t1_busy_after_start", r_busy0, 1);
    check("t1_beats", r_beats, 16);
    check("t1_ic_done_beats", r_ic_mask, 32'h0001_1110);
    check("t1_oc_done_beats", r_oc_mask, 32'h0001_0100);
    check("t1_gap_count", r_ngaps, 3);
    check("t1_gap_min", r_gap_min, 6);
    check("t1_gap_max", r_gap_max, 6);
    check("t1_ic_at_beat5", ic_at[5], 1);
    check("t1_oc_at_beat9", oc_at[9], 1);
    check("t1_ic_at_beat9", ic_at[9], 0);
    check("t1_ic_at_beat13", ic_at[13], 1);
    check("t1_results", r_res_sent, 8);
    check("t1_done_latency", r_done_cyc - r_last_res, 1);
    check("t1_spurious_done", r_spurious, 0);
    @(negedge clk); #1;
    check("t1_busy_after_done", busy, 0);

    // ---- Rejected start: npix above 2**AWIDTH ----
    start_tile(2, 2, 17);
    #1;
    check("rej17_err_same_cycle", cfg_err, 0);
    @(negedge clk); start = 1'b0; #1;
    check("rej17_err_pulse", cfg_err, 1);
    check("rej17_busy", busy, 0);
    check("rej17_no_dv", data_valid, 0);
    @(negedge clk); #1;
    check("rej17_err_one_cycle", cfg_err, 0);

    // ---- Rejected start: zero ic count ----
    start_tile(0, 2, 4);
    @(negedge clk); start = 1'b0; #1;
    check("rej0_err_pulse", cfg_err, 1);
    check("rej0_busy", busy, 0);

    // ---- Drain stall: noc=3 nic=1 npix=4, results withheld ----
    start_tile(1, 3, 4);
    begin
      int beats = 0;
      int stall_dv = 0;
      int sent = 0;
      bit seen_last_oc = 1'b0;
      for (int c = 0; c < 60 && beats < 8; c++) begin
        @(negedge clk); start = 1'b0; pe_ready = 1'b1; #1;
        if (data_valid) beats++;
      end
      check("stall_first_two_oc_beats", beats, 8);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk); #1;
        if (data_valid) stall_dv++;
      end
      for (int c = 0; c < 4; c++) begin
        @(negedge clk); result_valid = 1'b1; #1;
        if (data_valid) stall_dv++;
      end
      @(negedge clk); result_valid = 1'b0; #1;
      if (data_valid) stall_dv++;
      check("stall_no_dv", stall_dv, 0);
      @(negedge clk); #1;
      check("stall_release_dv", data_valid, 1);
      check("stall_release_oc", oc_idx, 2);
      beats = 1;
      done_at = -1;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        result_valid = seen_last_oc && (sent < 8);
        if (result_valid) sent++;
        #1;
        if (data_valid) beats++;
        if (oc_done) seen_last_oc = 1'b1;
        if (done) begin done_at = c; break; end
      end
      result_valid = 1'b0;
      check("stall_oc2_beats", beats, 4);
      check("stall_done_seen", done_at >= 0, 1);
    end

    // ---- pe_ready throttling, npix=3 ----
    start_tile(1, 1, 3);
    begin
      int dv_after = 0;
      done_at = -1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk); start = 1'b0; pe_ready = exp_pe[c]; #1;
        check($sformatf("pe_dv_c%0d", c), data_valid, exp_pe[c]);
        check($sformatf("pe_pix_c%0d", c), pix_idx, exp_pix[c]);
        check($sformatf("pe_icdone_c%0d", c), ic_done, (c == 4));
      end
      check("pe_oc_done_last", oc_done, 1);
      for (int c = 5; c < 40; c++) begin
        @(negedge clk);
        pe_ready = 1'b1;
        result_valid = (c >= 12 && c < 15);
        #1;
        if (data_valid) dv_after++;
        if (done) begin done_at = c; break; end
      end
      result_valid = 1'b0;
      check("pe_no_extra_dv", dv_after, 0);
      check("pe_done_cycle", done_at, 15);
    end

    // ---- Reset in the middle of ISSUE, then a full tile ----
    start_tile(2, 2, 4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); start = 1'b0; pe_ready = 1'b1;
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("midrst_outputs",
          {data_valid, ic_done, oc_done, busy, done, cfg_err, pix_idx, ic_idx, oc_idx}, 0);
    start_tile(2, 2, 4);
    run_tile(4, 200);
    check("post_rst_beats", r_beats, 16);
    check("post_rst_ic_done_beats", r_ic_mask, 32'h0001_1110);
    check("post_rst_oc_done_beats", r_oc_mask, 32'h0001_0100);
    check("post_rst_done_latency", r_done_cyc - r_last_res, 1);

    // ---- Degenerate tile 1x1x1 ----
    start_tile(1, 1, 1);
    run_tile(1, 100);
    check("one_beats", r_beats, 1);
    check("one_ic_done", r_ic_mask, 2);
    check("one_oc_done", r_oc_mask, 2);
    check("one_results", r_res_sent, 1);
    check("one_done_latency", r_done_cyc - r_last_res, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
